fir3_p2s: RTL and testbench

Parallel-to-serial output stage for the 3-parallel FIR datapath. It accepts one block of three filtered samples per handshake (`y3k`, `y3k_1`, `y3k_2`) and buffers blocks in a small FIFO. It replays the samples as a single in-order stream `yk` (index 3k, 3k+1, 3k+2) with valid/ready flow control. It sits between the FIR core outputs and any one-sample-per-cycle consumer, and reconstructs the serial sequence from the block-parallel outputs.

---
 rtl/fir3_p2s.sv | 115 +++++++++++
 tb/tb_fir3_p2s.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir3_p2s.sv
// Parallel-to-serial stage: buffers 3-sample blocks from the 3-parallel FIR and replays them one sample per cycle.
// Optional FIR3_P2S_LEVEL_EN adds a buffered-sample count output `level`.
module fir3_p2s #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] y3k,
    input  logic [DATA_W-1:0] y3k_1,
    input  logic [DATA_W-1:0] y3k_2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] yk
`ifdef FIR3_P2S_LEVEL_EN
    ,
    output logic [$clog2(3*DEPTH+1)-1:0] level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid/ready here depend only on registered state, never on the other side's signal.

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_t;

    logic [DATA_W-1:0] lane0 [DEPTH];
    logic [DATA_W-1:0] lane1 [DEPTH];
    logic [DATA_W-1:0] lane2 [DEPTH];

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    phase_t        phase;

    logic push;
    logic take;
    logic pop;

    assign in_ready  = (cnt != CW'(DEPTH));
    assign out_valid = (cnt != '0);

    // Flush masks both handshakes so the edge only clears state.
    assign push = in_valid && in_ready && !flush;
    assign take = out_valid && out_ready && !flush;
    assign pop  = take && (phase == PH2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            phase <= PH0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            phase <= PH0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (take) begin
                case (phase)
                    PH0:     phase <= PH1;
                    PH1:     phase <= PH2;
                    default: phase <= PH0;
                endcase
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sample storage carries no reset; validity is tracked entirely by cnt.
    always_ff @(posedge clk) begin
        if (push) begin
            lane0[wptr] <= y3k;
            lane1[wptr] <= y3k_1;
            lane2[wptr] <= y3k_2;
        end
    end

    always_comb begin
        yk = '0;
        if (out_valid) begin
            case (phase)
                PH0:     yk = lane0[rptr];
                PH1:     yk = lane1[rptr];
                default: yk = lane2[rptr];
            endcase
        end
    end

`ifdef FIR3_P2S_LEVEL_EN
    localparam int LW = $clog2(3*DEPTH+1);
    assign level = LW'(3 * cnt) - LW'(phase);
`endif

endmodule

// File: tb/tb_fir3_p2s.sv
// Self-checking bench for fir3_p2s: random and directed block traffic against a sample-queue reference model.
module tb_fir3_p2s;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] y3k;
    logic [DATA_W-1:0] y3k_1;
    logic [DATA_W-1:0] y3k_2;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] yk;
`ifdef FIR3_P2S_LEVEL_EN
    logic [$clog2(3*DEPTH+1)-1:0] level;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: flat queue of samples still owed to the consumer, in stream order.
    logic [DATA_W-1:0] exp_q[$];
    bit last_accept = 0;
    bit rnd_mode = 0;

    fir3_p2s #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y3k      (y3k),
        .y3k_1    (y3k_1),
        .y3k_2    (y3k_2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .yk       (yk)
`ifdef FIR3_P2S_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    // Checks at the falling edge, then applies what the coming rising edge will do to the model.
    always @(negedge clk) begin
        int blocks;
        bit acc;
        last_accept = 0;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            blocks = (exp_q.size() + 2) / 3;
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("in_ready", 32'(in_ready), 32'(blocks != DEPTH));
            check("yk", 32'(yk), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
`ifdef FIR3_P2S_LEVEL_EN
            check("level", 32'(level), 32'(exp_q.size()));
`endif
            if (flush) begin
                exp_q.delete();
            end else begin
                acc = in_valid && (blocks != DEPTH);
                if (exp_q.size() != 0 && out_ready) begin
                    void'(exp_q.pop_front());
                end
                if (acc) begin
                    exp_q.push_back(y3k);
                    exp_q.push_back(y3k_1);
                    exp_q.push_back(y3k_2);
                end
                last_accept = acc;
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_mode) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks (start and end at posedge+1) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_block(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                              input logic [DATA_W-1:0] c);
        int k;
        in_valid = 1'b1;
        y3k = a;
        y3k_1 = b;
        y3k_2 = c;
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (!last_accept && k < 300);
        if (!last_accept) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no accept expected accept within 300 cycles");
        end
        #1;
        in_valid = 1'b0;
        y3k = DATA_W'($urandom);
        y3k_1 = DATA_W'($urandom);
        y3k_2 = DATA_W'($urandom);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            idle(1);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d samples left expected 0", exp_q.size());
        end
        idle(2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        y3k = '0;
        y3k_1 = '0;
        y3k_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_yk", 32'(yk), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        idle(2);

        // single block, consumer always ready
        out_ready = 1'b1;
        send_block(16'h0001, 16'h0002, 16'h0003);
        idle(5);

        // fill to capacity, then a fifth block must be refused
        out_ready = 1'b0;
        for (int b = 0; b < DEPTH; b++) begin
            send_block(DATA_W'(16'h0100 + 3*b), DATA_W'(16'h0101 + 3*b), DATA_W'(16'h0102 + 3*b));
        end
        in_valid = 1'b1;
        y3k = 16'hAAAA;
        y3k_1 = 16'hBBBB;
        y3k_2 = 16'hCCCC;
        idle(3);
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // ramp 0..17 across the pointer wrap under random backpressure
        rnd_mode = 1;
        for (int b = 0; b < 6; b++) begin
            send_block(DATA_W'(3*b), DATA_W'(3*b + 1), DATA_W'(3*b + 2));
        end
        wait_drain();
        rnd_mode = 0;
        idle(1);

        // stall at phase 1 for 5 cycles
        out_ready = 1'b0;
        send_block(16'h1111, 16'h2222, 16'h3333);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        idle(5);
        out_ready = 1'b1;
        wait_drain();

        // flush at phase 2 with a block offered at the same edge
        out_ready = 1'b0;
        send_block(16'h000A, 16'h000B, 16'h000C);
        out_ready = 1'b1;
        idle(2);
        out_ready = 1'b0;
        flush = 1'b1;
        in_valid = 1'b1;
        y3k = 16'h7FFF;
        y3k_1 = 16'h8000;
        y3k_2 = 16'h0000;
        idle(1);
        flush = 1'b0;
        in_valid = 1'b0;
        idle(3);
        out_ready = 1'b1;
        send_block(16'h0020, 16'h0021, 16'h0022);
        wait_drain();

        // asynchronous reset between edges, mid-block
        out_ready = 1'b0;
        send_block(16'h0030, 16'h0031, 16'h0032);
        send_block(16'h0033, 16'h0034, 16'h0035);
        out_ready = 1'b1;
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_yk", 32'(yk), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_block(16'h1234, 16'h5678, 16'h9ABC);
        wait_drain();

        // random traffic
        rnd_mode = 1;
        for (int b = 0; b < 20; b++) begin
            send_block(DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        wait_drain();
        rnd_mode = 0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
